// File: rtl/sine_pkg.sv
// sine_pkg: shared types and defaults for the sine wave analyzer slice.
//   SAMPLE_W  - waveform sample width (unsigned)
//   MID_DEF   - default mid-scale crossing threshold
//   PERIOD_W  - default period counter / period output width
//   det_state_t - hysteresis detector states
package sine_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned MID_DEF  = 128;
  localparam int unsigned PERIOD_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_SEEK,
    ST_LOW,
    ST_HIGH
  } det_state_t;

endpackage

// File: rtl/sine_wave_analyzer_if.sv
// sine_wave_analyzer_if: sample stream in, measurement results out.
//   sample_in/sample_valid         - waveform samples (master -> slave)
//   period_out/peak_out/trough_out - last measured cycle (slave -> master)
//   meas_valid                     - one-cycle pulse, results updated
//   locked                         - two consecutive periods within tolerance
//   timeout                        - one-cycle pulse, period counter expired
// master: sample source / result consumer; slave: the analyzer.
interface sine_wave_analyzer_if #(
  parameter int unsigned PW = 16
);
  import sine_pkg::*;

  sample_t         sample_in;
  logic            sample_valid;
  logic [PW-1:0]   period_out;
  sample_t         peak_out;
  sample_t         trough_out;
  logic            meas_valid;
  logic            locked;
  logic            timeout;

  modport master (
    output sample_in, sample_valid,
    input  period_out, peak_out, trough_out, meas_valid, locked, timeout
  );

  modport slave (
    input  sample_in, sample_valid,
    output period_out, peak_out, trough_out, meas_valid, locked, timeout
  );
endinterface

// File: rtl/sine_crossing_detector.sv
// sine_crossing_detector: hysteresis FSM that flags rising mid-scale
// crossings. Evaluated on valid samples only.
//   clk, reset_n - clock, synchronous active-low reset
//   i_sample     - waveform sample
//   i_valid      - sample valid this cycle
//   i_restart    - force the FSM back to SEEK (takes priority)
//   o_rise       - combinational strobe: this sample is a rising crossing
module sine_crossing_detector
  import sine_pkg::*;
#(
  parameter int unsigned MID  = MID_DEF,
  parameter int unsigned HYST = 8
) (
  input  logic    clk,
  input  logic    reset_n,
  input  sample_t i_sample,
  input  logic    i_valid,
  input  logic    i_restart,
  output logic    o_rise
);

  localparam sample_t RISE_TH = sample_t'(MID + HYST);
  localparam sample_t FALL_TH = sample_t'(MID - HYST);

  det_state_t r_state;
  det_state_t w_next;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_SEEK;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_restart) begin
      w_next = ST_SEEK;
    end else if (i_valid) begin
      case (r_state)
        ST_SEEK: if (i_sample <= FALL_TH) w_next = ST_LOW;
        ST_LOW:  if (i_sample >= RISE_TH) w_next = ST_HIGH;
        ST_HIGH: if (i_sample <= FALL_TH) w_next = ST_LOW;
        default: w_next = ST_SEEK;
      endcase
    end
  end

  always_comb begin
    o_rise = i_valid && (r_state == ST_LOW) && (i_sample >= RISE_TH);
  end

endmodule

// File: rtl/sine_wave_analyzer.sv
// sine_wave_analyzer: measures period, peak and trough of each cycle of an
// unsigned sample stream, using rising mid-scale crossings with hysteresis.
//   clk      - clock
//   reset_n  - synchronous active-low reset
//   sif      - sine_wave_analyzer_if.slave (samples in, results out)
// Build option: SINE_ANALYZER_LOCK_EN enables the lock monitor (prev period
// register and tolerance comparator, parameter TOL); otherwise locked is 0.
module sine_wave_analyzer
  import sine_pkg::*;
#(
  parameter int unsigned MID  = MID_DEF,
  parameter int unsigned HYST = 8,
  parameter int unsigned PW   = PERIOD_W
`ifdef SINE_ANALYZER_LOCK_EN
  ,
  parameter int unsigned TOL  = 2
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sine_wave_analyzer_if.slave  sif
);

  // Last count before the counter would overflow: 2^PW-2.
  localparam logic [PW-1:0] CNT_LAST = {{(PW-1){1'b1}}, 1'b0};

  logic [PW-1:0] r_cnt;
  sample_t       r_peak_acc;
  sample_t       r_trough_acc;
  logic          r_first_seen;

  logic [PW-1:0] r_period;
  sample_t       r_peak;
  sample_t       r_trough;
  logic          r_meas_valid;
  logic          r_timeout;

  logic          w_rise;
  logic          w_timeout;
  logic          w_meas;
  logic [PW-1:0] w_period;
  sample_t       w_peak_win;
  sample_t       w_trough_win;

  sine_crossing_detector #(
    .MID  (MID),
    .HYST (HYST)
  ) u_det (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_sample  (sif.sample_in),
    .i_valid   (sif.sample_valid),
    .i_restart (w_timeout),
    .o_rise    (w_rise)
  );

  // Window extrema include the current sample, so a crossing sample is
  // folded into the result it closes.
  always_comb begin
    w_timeout    = sif.sample_valid && !w_rise && (r_cnt == CNT_LAST);
    w_meas       = w_rise && r_first_seen;
    w_period     = r_cnt + PW'(1);
    w_peak_win   = (sif.sample_in > r_peak_acc)   ? sif.sample_in : r_peak_acc;
    w_trough_win = (sif.sample_in < r_trough_acc) ? sif.sample_in : r_trough_acc;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_peak_acc   <= '0;
      r_trough_acc <= '1;
      r_first_seen <= 1'b0;
      r_period     <= '0;
      r_peak       <= '0;
      r_trough     <= '0;
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
      if (sif.sample_valid) begin
        if (w_rise) begin
          if (w_meas) begin
            r_period     <= w_period;
            r_peak       <= w_peak_win;
            r_trough     <= w_trough_win;
            r_meas_valid <= 1'b1;
          end
          r_cnt        <= '0;
          r_first_seen <= 1'b1;
          r_peak_acc   <= '0;
          r_trough_acc <= '1;
        end else if (w_timeout) begin
          r_cnt        <= '0;
          r_first_seen <= 1'b0;
          r_timeout    <= 1'b1;
          r_peak_acc   <= '0;
          r_trough_acc <= '1;
        end else begin
          r_cnt        <= r_cnt + PW'(1);
          r_peak_acc   <= w_peak_win;
          r_trough_acc <= w_trough_win;
        end
      end
    end
  end

`ifdef SINE_ANALYZER_LOCK_EN
  logic [PW-1:0] r_prev;
  logic          r_prev_ok;
  logic          r_locked;
  logic [PW:0]   w_diff;

  // |new - prev| computed in PW+1 bits: sign bit selects negation.
  always_comb begin
    w_diff = {1'b0, w_period} - {1'b0, r_prev};
    if (w_diff[PW]) w_diff = -w_diff;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_locked  <= 1'b0;
      r_prev    <= '0;
      r_prev_ok <= 1'b0;
    end else if (w_meas) begin
      r_locked  <= r_prev_ok && (w_diff <= (PW+1)'(TOL));
      r_prev    <= w_period;
      r_prev_ok <= 1'b1;
    end else if (w_timeout) begin
      r_locked  <= 1'b0;
      r_prev_ok <= 1'b0;
    end
  end

  assign sif.locked = r_locked;
`else
  assign sif.locked = 1'b0;
`endif

  assign sif.period_out = r_period;
  assign sif.peak_out   = r_peak;
  assign sif.trough_out = r_trough;
  assign sif.meas_valid = r_meas_valid;
  assign sif.timeout    = r_timeout;

endmodule

// File: tb/tb_sine_wave_analyzer.sv
// tb_sine_wave_analyzer: self-checking bench for sine_wave_analyzer.
// Expected measurements are pushed to a scoreboard queue when the closing
// crossing sample is driven and popped when meas_valid is seen.
// Honours SINE_ANALYZER_LOCK_EN for the expected value of locked.
module tb_sine_wave_analyzer;

`ifdef SINE_ANALYZER_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  localparam real PI = 3.14159265358979;

  typedef struct {
    logic [15:0] period;
    logic [7:0]  peak;
    logic [7:0]  trough;
    logic        lk;
    bit          chk_lk;
  } meas_t;

  logic       clk;
  logic       reset_n;
  logic [7:0] tbl [256];
  meas_t      sb [$];
  int         n_vec;
  int         n_err;

  sine_wave_analyzer_if #(.PW(16)) sif ();

  sine_wave_analyzer #(
    .MID  (128),
    .HYST (8),
    .PW   (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sif     (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [7:0] s);
    sif.sample_valid = v;
    sif.sample_in    = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(1'b0, 8'd0);
    reset_n = 1'b1;
    sb.delete();
  endtask

  task automatic push(input int p, input int pk, input int tr, input bit lk, input bit chk);
    meas_t e;
    e.period = 16'(p);
    e.peak   = 8'(pk);
    e.trough = 8'(tr);
    e.lk     = LOCK_EN && lk;
    e.chk_lk = chk;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(1'b1, 8'd200);
    step(1'b1, 8'd0);
    step(1'b1, 8'd255);
    n_vec++; if (sif.period_out !== 16'd0) begin n_err++; $display("FAIL reset_period got %0d want 0", sif.period_out); end
    n_vec++; if (sif.peak_out !== 8'd0) begin n_err++; $display("FAIL reset_peak got %0d want 0", sif.peak_out); end
    n_vec++; if (sif.trough_out !== 8'd0) begin n_err++; $display("FAIL reset_trough got %0d want 0", sif.trough_out); end
    n_vec++; if (sif.meas_valid !== 1'b0) begin n_err++; $display("FAIL reset_meas_valid got %b want 0", sif.meas_valid); end
    n_vec++; if (sif.locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got %b want 0", sif.locked); end
    n_vec++; if (sif.timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b want 0", sif.timeout); end
    reset_n = 1'b1;
    sb.delete();
  endtask

  // Starts at the trough (index 192) so the crossing at index 3 of the next
  // cycle (absolute 259) is the arming crossing.
  task automatic test_generator();
    meas_t m;
    for (int idx = 192; idx <= 771; idx++) begin
      if (idx == 515 || idx == 771) push(256, 255, 1, idx == 771, 1'b1);
      step(1'b1, tbl[idx % 256]);
      if (sif.meas_valid === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL gen_meas unexpected meas_valid idx %0d got p=%0d want none", idx, sif.period_out);
        end else begin
          m = sb.pop_front();
          if (sif.period_out !== m.period || sif.peak_out !== m.peak || sif.trough_out !== m.trough ||
              (m.chk_lk && sif.locked !== m.lk)) begin
            n_err++;
            $display("FAIL gen_meas idx %0d got p=%0d pk=%0d tr=%0d lk=%b want p=%0d pk=%0d tr=%0d lk=%b",
                     idx, sif.period_out, sif.peak_out, sif.trough_out, sif.locked, m.period, m.peak, m.trough, m.lk);
          end
        end
      end else if (sb.size() != 0) begin
        n_vec++; n_err++; $display("FAIL gen_meas missing meas_valid idx %0d got 0 want 1", idx); sb.delete();
      end
    end
    step(1'b0, 8'd77);
    n_vec++;
    if (sif.meas_valid !== 1'b0 || sif.period_out !== 16'd256 || sif.peak_out !== 8'd255 || sif.trough_out !== 8'd1) begin
      n_err++;
      $display("FAIL gen_hold got mv=%b p=%0d pk=%0d tr=%0d want mv=0 p=256 pk=255 tr=1",
               sif.meas_valid, sif.period_out, sif.peak_out, sif.trough_out);
    end
  endtask

  // Continues from test_generator: FSM is HIGH with cnt=0, so the noise
  // never crosses and the 65535th noise sample times out.
  task automatic test_timeout();
    meas_t      m;
    logic [7:0] noise [4];
    logic [7:0] s;
    int         to_first;
    int         to_cnt;
    noise    = '{8'd130, 8'd126, 8'd131, 8'd125};
    to_first = -1;
    to_cnt   = 0;
    for (int k = 0; k < 65535 + 324; k++) begin
      if (k < 65535) begin
        s = noise[k % 4];
      end else begin
        s = tbl[(192 + k - 65535) % 256];
        if (192 + k - 65535 == 515) push(256, 255, 1, 1'b0, 1'b0);
      end
      step(1'b1, s);
      if (sif.timeout === 1'b1) begin
        to_cnt++;
        if (to_first < 0) to_first = k;
        n_vec++;
        if (sif.locked !== 1'b0 || sif.period_out !== 16'd256 || sif.peak_out !== 8'd255 || sif.trough_out !== 8'd1) begin
          n_err++;
          $display("FAIL to_hold k %0d got lk=%b p=%0d pk=%0d tr=%0d want lk=0 p=256 pk=255 tr=1",
                   k, sif.locked, sif.period_out, sif.peak_out, sif.trough_out);
        end
      end
      if (sif.meas_valid === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL to_meas unexpected meas_valid k %0d got p=%0d want none", k, sif.period_out);
        end else begin
          m = sb.pop_front();
          if (sif.period_out !== m.period || sif.peak_out !== m.peak || sif.trough_out !== m.trough ||
              (m.chk_lk && sif.locked !== m.lk)) begin
            n_err++;
            $display("FAIL to_meas k %0d got p=%0d pk=%0d tr=%0d lk=%b want p=%0d pk=%0d tr=%0d lk=%b",
                     k, sif.period_out, sif.peak_out, sif.trough_out, sif.locked, m.period, m.peak, m.trough, m.lk);
          end
        end
      end else if (sb.size() != 0) begin
        n_vec++; n_err++; $display("FAIL to_meas missing meas_valid k %0d got 0 want 1", k); sb.delete();
      end
    end
    n_vec++;
    if (to_first != 65534 || to_cnt != 1) begin
      n_err++; $display("FAIL to_pulse got first=%0d count=%0d want first=65534 count=1", to_first, to_cnt);
    end
  endtask

  task automatic test_half_rate();
    meas_t m;
    logic [15:0] h_p;
    logic [7:0]  h_pk, h_tr;
    logic        h_lk;
    do_reset();
    h_p = '0; h_pk = '0; h_tr = '0; h_lk = 1'b0;
    for (int idx = 192; idx <= 771; idx++) begin
      if (idx == 515 || idx == 771) push(256, 255, 1, idx == 771, 1'b1);
      step(1'b1, tbl[idx % 256]);
      if (sif.meas_valid === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL half_meas unexpected meas_valid idx %0d got p=%0d want none", idx, sif.period_out);
        end else begin
          m = sb.pop_front();
          h_p = m.period; h_pk = m.peak; h_tr = m.trough; h_lk = m.lk;
          if (sif.period_out !== m.period || sif.peak_out !== m.peak || sif.trough_out !== m.trough ||
              (m.chk_lk && sif.locked !== m.lk)) begin
            n_err++;
            $display("FAIL half_meas idx %0d got p=%0d pk=%0d tr=%0d lk=%b want p=%0d pk=%0d tr=%0d lk=%b",
                     idx, sif.period_out, sif.peak_out, sif.trough_out, sif.locked, m.period, m.peak, m.trough, m.lk);
          end
        end
      end else if (sb.size() != 0) begin
        n_vec++; n_err++; $display("FAIL half_meas missing meas_valid idx %0d got 0 want 1", idx); sb.delete();
      end
      step(1'b0, 8'(255 - int'(tbl[idx % 256])));
      n_vec++;
      if (sif.meas_valid !== 1'b0 || sif.period_out !== h_p || sif.peak_out !== h_pk ||
          sif.trough_out !== h_tr || sif.locked !== h_lk) begin
        n_err++;
        $display("FAIL half_idle idx %0d got mv=%b p=%0d pk=%0d tr=%0d lk=%b want mv=0 p=%0d pk=%0d tr=%0d lk=%b",
                 idx, sif.meas_valid, sif.period_out, sif.peak_out, sif.trough_out, sif.locked, h_p, h_pk, h_tr, h_lk);
      end
    end
  endtask

  // 256-sample cycles, then odd table indices only (128-sample cycles);
  // odd decimation keeps the crossing on index 3 so the first short
  // period is exactly 128.
  task automatic test_period_step();
    meas_t m;
    int    idx;
    do_reset();
    for (int n = 0; n <= 835; n++) begin
      idx = (n <= 579) ? 192 + n : 773 + 2 * (n - 580);
      if (idx % 256 == 3 && idx >= 515)
        push((idx <= 771) ? 256 : 128, 255, 1, idx == 771 || idx == 1283, 1'b1);
      step(1'b1, tbl[idx % 256]);
      if (sif.meas_valid === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL step_meas unexpected meas_valid idx %0d got p=%0d want none", idx, sif.period_out);
        end else begin
          m = sb.pop_front();
          if (sif.period_out !== m.period || sif.peak_out !== m.peak || sif.trough_out !== m.trough ||
              (m.chk_lk && sif.locked !== m.lk)) begin
            n_err++;
            $display("FAIL step_meas idx %0d got p=%0d pk=%0d tr=%0d lk=%b want p=%0d pk=%0d tr=%0d lk=%b",
                     idx, sif.period_out, sif.peak_out, sif.trough_out, sif.locked, m.period, m.peak, m.trough, m.lk);
          end
        end
      end else if (sb.size() != 0) begin
        n_vec++; n_err++; $display("FAIL step_meas missing meas_valid idx %0d got 0 want 1", idx); sb.delete();
      end
    end
  endtask

  task automatic test_reset_mid();
    meas_t m;
    do_reset();
    for (int idx = 192; idx <= 1027; idx++) begin
      if (idx == 515 || idx == 1027) push(256, 255, 1, 1'b0, 1'b1);
      if (idx == 601) begin
        reset_n = 1'b0;
        step(1'b1, tbl[idx % 256]);
        reset_n = 1'b1;
        n_vec++;
        if (sif.period_out !== 16'd0 || sif.peak_out !== 8'd0 || sif.trough_out !== 8'd0 ||
            sif.meas_valid !== 1'b0 || sif.locked !== 1'b0 || sif.timeout !== 1'b0) begin
          n_err++;
          $display("FAIL rmid_zero got p=%0d pk=%0d tr=%0d mv=%b lk=%b to=%b want all 0",
                   sif.period_out, sif.peak_out, sif.trough_out, sif.meas_valid, sif.locked, sif.timeout);
        end
      end else begin
        step(1'b1, tbl[idx % 256]);
      end
      if (sif.meas_valid === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL rmid_meas unexpected meas_valid idx %0d got p=%0d want none", idx, sif.period_out);
        end else begin
          m = sb.pop_front();
          if (sif.period_out !== m.period || sif.peak_out !== m.peak || sif.trough_out !== m.trough ||
              (m.chk_lk && sif.locked !== m.lk)) begin
            n_err++;
            $display("FAIL rmid_meas idx %0d got p=%0d pk=%0d tr=%0d lk=%b want p=%0d pk=%0d tr=%0d lk=%b",
                     idx, sif.period_out, sif.peak_out, sif.trough_out, sif.locked, m.period, m.peak, m.trough, m.lk);
          end
        end
      end else if (sb.size() != 0) begin
        n_vec++; n_err++; $display("FAIL rmid_meas missing meas_valid idx %0d got 0 want 1", idx); sb.delete();
      end
    end
  endtask

  task automatic test_square();
    meas_t m;
    do_reset();
    for (int k = 0; k < 80; k++) begin
      if (k == 30 || k == 50 || k == 70) push(20, 255, 0, k != 30, 1'b1);
      step(1'b1, ((k / 10) % 2 == 1) ? 8'd255 : 8'd0);
      if (sif.meas_valid === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL sq_meas unexpected meas_valid k %0d got p=%0d want none", k, sif.period_out);
        end else begin
          m = sb.pop_front();
          if (sif.period_out !== m.period || sif.peak_out !== m.peak || sif.trough_out !== m.trough ||
              (m.chk_lk && sif.locked !== m.lk)) begin
            n_err++;
            $display("FAIL sq_meas k %0d got p=%0d pk=%0d tr=%0d lk=%b want p=%0d pk=%0d tr=%0d lk=%b",
                     k, sif.period_out, sif.peak_out, sif.trough_out, sif.locked, m.period, m.peak, m.trough, m.lk);
          end
        end
      end else if (sb.size() != 0) begin
        n_vec++; n_err++; $display("FAIL sq_meas missing meas_valid k %0d got 0 want 1", k); sb.delete();
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    sif.sample_valid = 1'b0;
    sif.sample_in = 8'd0;
    for (int i = 0; i < 256; i++)
      tbl[i] = 8'($rtoi($floor(128.0 + 127.0 * $sin(2.0 * PI * i / 256.0) + 0.5)));
    test_reset();
    test_generator();
    test_timeout();
    test_half_rate();
    test_period_step();
    test_reset_mid();
    test_square();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
